// File: rtl/sat_counter_monitor.sv
// Bank of independent up/down counters with saturate-or-wrap behaviour, sticky
// overflow/underflow flags and per-channel status LEDs sharing one blink phase.
module sat_counter_monitor #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int SAT_MODE  = 1,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS-1:0]       clr,
  input  logic                      flag_clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       at_max,
  output logic [CHANNELS-1:0]       at_min,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf,
  output logic [CHANNELS-1:0]       led_g,
  output logic [CHANNELS-1:0]       led_r
);

  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  // Packed so channel i lands at bits [i*WIDTH +: WIDTH] of count directly.
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_d;
  logic [CHANNELS-1:0]            ovf_q;
  logic [CHANNELS-1:0]            unf_q;
  logic [CHANNELS-1:0]            ovf_set;
  logic [CHANNELS-1:0]            unf_set;
  logic [DIV_W-1:0]               div_q;
  logic                           blink_q;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = '0;
    unf_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr[i]) begin
        cnt_d[i] = '0;
      end else if (inc[i] && !dec[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = (SAT_MODE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) begin
          unf_set[i] = 1'b1;
          cnt_d[i]   = (SAT_MODE != 0) ? cnt_q[i] : '1;
        end else begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end
      end
    end
  end

  // A flag set in the same cycle as flag_clr survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= (ovf_q & ~{CHANNELS{flag_clr}}) | ovf_set;
      unf_q <= (unf_q & ~{CHANNELS{flag_clr}}) | unf_set;
    end
  end

  // Free-running divider; blink has a period of 2*BLINK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      blink_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_comb begin
    at_max = '0;
    at_min = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      at_max[i] = (cnt_q[i] == '1);
      at_min[i] = (cnt_q[i] == '0);
    end
  end

  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign led_g = at_max | (ovf_q & {CHANNELS{blink_q}});
  assign led_r = at_min | (unf_q & {CHANNELS{blink_q}});

endmodule

// File: tb/tb_sat_counter_monitor.sv
// Directed bench for sat_counter_monitor: a saturating and a wrapping instance
// share the same stimulus; expected values are hand-computed per step.
module tb_sat_counter_monitor;

  logic       clk;
  logic       rst_n;
  logic [1:0] inc;
  logic [1:0] dec;
  logic [1:0] clr;
  logic       flag_clr;

  logic [7:0] count_s,  count_w;
  logic [1:0] at_max_s, at_max_w;
  logic [1:0] at_min_s, at_min_w;
  logic [1:0] ovf_s,    ovf_w;
  logic [1:0] unf_s,    unf_w;
  logic [1:0] led_g_s,  led_g_w;
  logic [1:0] led_r_s,  led_r_w;

  int n_checks;
  int n_pass;
  int edges;

  sat_counter_monitor #(.WIDTH(4), .CHANNELS(2), .SAT_MODE(1), .BLINK_DIV(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr), .flag_clr(flag_clr),
    .count(count_s), .at_max(at_max_s), .at_min(at_min_s), .ovf(ovf_s), .unf(unf_s),
    .led_g(led_g_s), .led_r(led_r_s)
  );

  sat_counter_monitor #(.WIDTH(4), .CHANNELS(2), .SAT_MODE(0), .BLINK_DIV(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr), .flag_clr(flag_clr),
    .count(count_w), .at_max(at_max_w), .at_min(at_min_w), .ovf(ovf_w), .unf(unf_w),
    .led_g(led_g_w), .led_r(led_r_w)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  function automatic logic blink_exp();
    return 1'((edges / 4) % 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " count"},  32'(count_s),  32'h00);
    check({tag, " at_min"}, 32'(at_min_s), 32'h3);
    check({tag, " at_max"}, 32'(at_max_s), 32'h0);
    check({tag, " led_r"},  32'(led_r_s),  32'h3);
    check({tag, " led_g"},  32'(led_g_s),  32'h0);
    check({tag, " ovf"},    32'(ovf_s),    32'h0);
    check({tag, " unf"},    32'(unf_s),    32'h0);
    check({tag, " w count"}, 32'(count_w), 32'h00);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    edges    = 0;
    rst_n    = 1'b0;
    inc      = '0;
    dec      = '0;
    clr      = '0;
    flag_clr = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    edges = 0;

    // channel 0 counts up and saturates, overflow latched on edge 16
    inc = 2'b01;
    for (int n = 1; n <= 17; n++) begin
      step();
      check($sformatf("inc0 count e%0d", n), 32'(count_s[3:0]), (n > 15) ? 32'd15 : 32'(n));
      check($sformatf("inc0 ovf e%0d", n), 32'(ovf_s[0]), (n >= 16) ? 32'd1 : 32'd0);
    end
    inc = 2'b00;
    check("inc0 led_g0", 32'(led_g_s[0]), 32'd1);
    check("inc0 at_max", 32'(at_max_s), 32'h1);
    check("inc0 ch1 idle", 32'(count_s[7:4]), 32'd0);
    check("inc0 unf", 32'(unf_s), 32'h0);
    check("wrap inc0 count", 32'(count_w[3:0]), 32'd1);
    check("wrap inc0 ovf", 32'(ovf_w), 32'h1);

    // underflow on channel 1, then blinking red once away from zero
    dec = 2'b10;
    step();
    dec = 2'b00;
    check("dec1 unf", 32'(unf_s), 32'h2);
    check("dec1 count", 32'(count_s[7:4]), 32'd0);
    check("dec1 led_r1", 32'(led_r_s[1]), 32'd1);
    inc = 2'b10;
    repeat (5) step();
    inc = 2'b00;
    check("raise1 count", 32'(count_s), 32'h5F);
    check("raise1 at_min", 32'(at_min_s), 32'h0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("blink led_r1 e%0d", edges), 32'(led_r_s[1]), 32'(blink_exp()));
      step();
    end
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("flag_clr unf", 32'(unf_s), 32'h0);
    check("flag_clr ovf", 32'(ovf_s), 32'h0);
    check("flag_clr led_r1", 32'(led_r_s[1]), 32'd0);
    check("flag_clr led_g0", 32'(led_g_s[0]), 32'd1);

    // inc and dec together hold; clr beats inc
    inc = 2'b11;
    dec = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("incdec count c%0d", k), 32'(count_s), 32'h5F);
      check($sformatf("incdec flags c%0d", k), 32'({ovf_s, unf_s}), 32'h0);
    end
    dec = 2'b00;
    inc = 2'b01;
    clr = 2'b01;
    step();
    clr = 2'b00;
    inc = 2'b00;
    check("clr+inc count", 32'(count_s), 32'h50);

    // overflow wins against flag_clr in the same cycle, then blinking green
    inc = 2'b01;
    repeat (15) step();
    check("refill count", 32'(count_s[3:0]), 32'd15);
    check("refill ovf", 32'(ovf_s), 32'h0);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    inc = 2'b00;
    check("ovf vs flag_clr", 32'(ovf_s), 32'h1);
    dec = 2'b01;
    step();
    dec = 2'b00;
    check("dec0 count", 32'(count_s[3:0]), 32'd14);
    check("dec0 at_max", 32'(at_max_s), 32'h0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("blink led_g0 e%0d", edges), 32'(led_g_s[0]), 32'(blink_exp()));
      step();
    end

    // asynchronous reset in the middle of counting
    inc = 2'b11;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async rst");
    inc = 2'b00;
    @(posedge clk);
    #1;
    check_reset_outputs("rst held");
    rst_n = 1'b1;
    edges = 0;

    // wrap instance: 0 -> 15 with unf, 15 -> 0 with ovf
    dec = 2'b01;
    step();
    dec = 2'b00;
    check("wrap dec count", 32'(count_w[3:0]), 32'd15);
    check("wrap dec unf", 32'(unf_w), 32'h1);
    check("sat dec count", 32'(count_s[3:0]), 32'd0);
    check("sat dec unf", 32'(unf_s), 32'h1);
    inc = 2'b01;
    step();
    inc = 2'b00;
    check("wrap inc count", 32'(count_w[3:0]), 32'd0);
    check("wrap inc ovf", 32'(ovf_w), 32'h1);
    check("sat inc count", 32'(count_s[3:0]), 32'd1);
    check("sat inc ovf", 32'(ovf_s), 32'h0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sat_counter_monitor.md
SAT_COUNTER_MONITOR -- requirements
Module: sat_counter_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter bits per channel, minimum 2.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent counters, minimum 1.
REQ-003 SHALL have parameter SAT_MODE, default 1: 1 = saturate at the limits, 0 = wrap around.
REQ-004 SHALL have parameter BLINK_DIV, default 25000000: clock cycles per LED blink half-period, minimum 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port inc, input, CHANNELS bits: per-channel increment request, one step per cycle while high.
REQ-008 SHALL have port dec, input, CHANNELS bits: per-channel decrement request.
REQ-009 SHALL have port clr, input, CHANNELS bits: per-channel synchronous clear of the count to 0.
REQ-010 SHALL have port flag_clr, input, 1 bit: global synchronous clear of all sticky flags.
REQ-011 SHALL have port count, output, CHANNELS*WIDTH bits: registered counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port at_max, output, CHANNELS bits: count equals all-ones.
REQ-013 SHALL have port at_min, output, CHANNELS bits: count equals 0.
REQ-014 SHALL have port ovf, output, CHANNELS bits: sticky flag, an increment was attempted at all-ones.
REQ-015 SHALL have port unf, output, CHANNELS bits: sticky flag, a decrement was attempted at 0.
REQ-016 SHALL have port led_g, output, CHANNELS bits: green LED drive per channel.
REQ-017 SHALL have port led_r, output, CHANNELS bits: red LED drive per channel.

Function
REQ-018 SHALL give each channel's count a next value with priority: clr -> 0; else inc and dec both high -> unchanged; else inc -> +1; else dec -> -1; else unchanged.
REQ-019 SHALL, with SAT_MODE=1, hold the count at all-ones on inc (no wrap) and at 0 on dec.
REQ-020 SHALL, with SAT_MODE=0, wrap the count from all-ones to 0 on inc and from 0 to all-ones on dec, using modulo 2^WIDTH arithmetic.
REQ-021 SHALL update count one cycle after the request is sampled; at_max and at_min are decoded combinationally from the registered count and are valid in the same cycle as count.
REQ-022 SHALL set ovf[i] on the edge where an effective inc occurs with count at all-ones (no clr, no simultaneous dec), in either mode.
REQ-023 SHALL set unf[i] on the edge where an effective dec occurs with count at 0, in either mode.
REQ-024 SHALL have flag_clr clear all ovf and unf bits on the next edge; if a set condition occurs for a bit in the same cycle, the set wins.
REQ-025 SHALL NOT have clr[i] affect ovf[i] or unf[i].
REQ-026 SHALL keep one shared blink divider: counts 0..BLINK_DIV-1, toggles the internal phase blink on wrap, period 2*BLINK_DIV cycles; the divider SHALL NOT stop.
REQ-027 SHALL drive led_g[i] = at_max[i] OR (ovf[i] AND blink): steady on at max, blinking while an overflow is latched.
REQ-028 SHALL drive led_r[i] = at_min[i] OR (unf[i] AND blink).
REQ-029 SHALL operate channels fully independently, except for the shared blink phase and flag_clr.

Reset
REQ-030 SHALL, while rst_n is low, immediately force all counts to 0, ovf and unf to 0, the blink divider to 0 and blink to 0, regardless of clk.
REQ-031 SHALL consequently hold at_min all-ones, at_max 0, led_r all-ones and led_g 0 during reset (at_max is also 1 only when WIDTH would be 0, which is disallowed).
REQ-032 SHALL resume on the first rising edge after rst_n goes high; a reset asserted mid-count SHALL discard all channel state with no partial update.

Verification (WIDTH=4, CHANNELS=2, BLINK_DIV=4, SAT_MODE=1 unless stated)
REQ-033 Bench SHALL check: reset -> count=0x00, at_min=2'b11, led_r=2'b11, led_g=0, ovf=unf=0.
REQ-034 Bench SHALL check: inc[0] held 17 cycles -> count[3:0] reaches 15 after 15 edges and stays 15; ovf[0] set at edge 16; led_g[0]=1; channel 1 stays 0.
REQ-035 Bench SHALL check: dec[1] pulsed at 0 -> unf[1]=1; after count is raised to 5, led_r[1] toggles every 4 cycles; flag_clr -> unf[1]=0, led_r[1]=0.
REQ-036 Bench SHALL check: inc=dec=2'b11 for 3 cycles -> counts unchanged and no flags; clr[0] together with inc[0] -> count 0.
REQ-037 Bench SHALL check: SAT_MODE=0, count 15, inc -> count 0, ovf=1; count 0, dec -> count 15, unf=1.
REQ-038 Bench SHALL check: flag_clr in the same cycle as an overflow event -> ovf remains 1; rst_n pulsed low mid-sequence -> all outputs return to reset values asynchronously.
